// File: rtl/or3_stim_chk_if.sv
// Stimulus/response bundle between the OR3 stimulus checker and its harness.
// Optional GLITCH_CNT appears only when OR3_STIM_GLITCH_CHK_EN is defined.
interface or3_stim_chk_if #(
  parameter int CNT_W = 16
);
  logic             i_start;
  logic             i_mode;
  logic             i_q;
  logic             o_in1;
  logic             o_in2;
  logic             o_in3;
  logic             o_busy;
  logic             o_done;
  logic             o_fail;
  logic [CNT_W-1:0] o_err_cnt;
  logic [CNT_W-1:0] o_tog_cnt;
`ifdef OR3_STIM_GLITCH_CHK_EN
  logic [CNT_W-1:0] o_glitch_cnt;
`endif

  modport slave (
`ifdef OR3_STIM_GLITCH_CHK_EN
    output o_glitch_cnt,
`endif
    input  i_start, i_mode, i_q,
    output o_in1, o_in2, o_in3, o_busy, o_done, o_fail, o_err_cnt, o_tog_cnt
  );

  modport master (
`ifdef OR3_STIM_GLITCH_CHK_EN
    input  o_glitch_cnt,
`endif
    output i_start, i_mode, i_q,
    input  o_in1, o_in2, o_in3, o_busy, o_done, o_fail, o_err_cnt, o_tog_cnt
  );
endinterface

// File: rtl/or3_stim_chk.sv
// Stimulus driver / response checker for a 3-input OR cell: sweeps all 8 vectors,
// samples Q after a settle window, counts mismatches and input toggles.
// Optional settle-window glitch counter enabled by defining OR3_STIM_GLITCH_CHK_EN.
module or3_stim_chk #(
  parameter int SETTLE_CYC = 2,
  parameter int NUM_PASSES = 4,
  parameter int CNT_W      = 16
) (
  input  logic          i_clk,
  input  logic          i_rstb,
  or3_stim_chk_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [7:0] LAST_PASS   = 8'(NUM_PASSES - 1);

  logic [2:0]       r_state;
  logic             r_mode;
  logic [2:0]       r_idx;
  logic [7:0]       r_pass;
  logic [3:0]       r_settle;
  logic [2:0]       r_vec;
  logic             r_first;
  logic             r_busy;
  logic             r_done;
  logic             r_fail;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_tog_cnt;

  logic [2:0] w_vec_nxt;
  logic [2:0] w_prev;
  logic [1:0] w_tog_add;
  logic       w_mism;

  function automatic logic [2:0] vec_of(input logic mode, input logic [2:0] idx);
    logic [2:0] v;
    if (mode == 1'b0) begin
      v = idx;
    end else begin
      case (idx)
        3'd0:    v = 3'b000;
        3'd1:    v = 3'b001;
        3'd2:    v = 3'b011;
        3'd3:    v = 3'b010;
        3'd4:    v = 3'b110;
        3'd5:    v = 3'b111;
        3'd6:    v = 3'b101;
        3'd7:    v = 3'b100;
        default: v = 3'b000;
      endcase
    end
    return v;
  endfunction

  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Next vector, toggle weight against the previous drive, and Q mismatch.
  always_comb begin
    w_vec_nxt = vec_of(r_mode, r_idx);
    if (r_first) begin
      w_prev = 3'b000;
    end else begin
      w_prev = r_vec;
    end
    w_tog_add = popcnt3(w_vec_nxt ^ w_prev);
    w_mism    = (bus.i_q != (|r_vec));
  end

  // Main sweep FSM with run counters and status flags.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_state   <= ST_IDLE;
      r_mode    <= 1'b0;
      r_idx     <= 3'd0;
      r_pass    <= 8'd0;
      r_settle  <= 4'd0;
      r_vec     <= 3'b000;
      r_first   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
      r_err_cnt <= {CNT_W{1'b0}};
      r_tog_cnt <= {CNT_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_err_cnt <= {CNT_W{1'b0}};
            r_tog_cnt <= {CNT_W{1'b0}};
            r_fail    <= 1'b0;
            r_mode    <= bus.i_mode;
            r_idx     <= 3'd0;
            r_pass    <= 8'd0;
            r_first   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_DRIVE;
          end else begin
            r_state   <= ST_IDLE;
          end
        end
        ST_DRIVE: begin
          r_vec     <= w_vec_nxt;
          r_tog_cnt <= sat_add(r_tog_cnt, w_tog_add);
          r_first   <= 1'b0;
          r_settle  <= SETTLE_LOAD;
          r_state   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_settle == 4'd0) begin
            r_state  <= ST_SAMPLE;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (w_mism) begin
            r_err_cnt <= sat_add(r_err_cnt, 2'd1);
            r_fail    <= 1'b1;
          end else begin
            r_fail    <= r_fail;
          end
          if (r_idx != 3'd7) begin
            r_idx   <= r_idx + 3'd1;
            r_state <= ST_DRIVE;
          end else if (r_pass != LAST_PASS) begin
            r_idx   <= 3'd0;
            r_pass  <= r_pass + 8'd1;
            r_state <= ST_DRIVE;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef OR3_STIM_GLITCH_CHK_EN
  logic [CNT_W-1:0] r_glitch_cnt;

  // Q is checked on every settle cycle except the first one after DRIVE.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_glitch_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == ST_IDLE) && bus.i_start) begin
      r_glitch_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == ST_SETTLE) && (r_settle != SETTLE_LOAD) && w_mism) begin
      r_glitch_cnt <= sat_add(r_glitch_cnt, 2'd1);
    end else begin
      r_glitch_cnt <= r_glitch_cnt;
    end
  end

  assign bus.o_glitch_cnt = r_glitch_cnt;
`endif

  assign bus.o_in1     = r_vec[0];
  assign bus.o_in2     = r_vec[1];
  assign bus.o_in3     = r_vec[2];
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_fail    = r_fail;
  assign bus.o_err_cnt = r_err_cnt;
  assign bus.o_tog_cnt = r_tog_cnt;

endmodule

// File: tb/tb_or3_stim_chk.sv
// Self-checking bench for or3_stim_chk: table of directed runs on three parameter
// sets plus hand-written reset-abort, held-START and (optional) glitch sequences.
module tb_or3_stim_chk;

  logic       clk = 1'b0;
  logic       rstb;
  logic       start;
  logic       mode;
  logic [1:0] sel;
  logic [1:0] qsel;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  or3_stim_chk_if #(.CNT_W(16)) if_a ();
  or3_stim_chk_if #(.CNT_W(16)) if_b ();
  or3_stim_chk_if #(.CNT_W(16)) if_c ();

  or3_stim_chk #(.SETTLE_CYC(2), .NUM_PASSES(1), .CNT_W(16)) u_a (.i_clk(clk), .i_rstb(rstb), .bus(if_a));
  or3_stim_chk #(.SETTLE_CYC(2), .NUM_PASSES(4), .CNT_W(16)) u_b (.i_clk(clk), .i_rstb(rstb), .bus(if_b));
  or3_stim_chk #(.SETTLE_CYC(2), .NUM_PASSES(2), .CNT_W(16)) u_c (.i_clk(clk), .i_rstb(rstb), .bus(if_c));

  // Cell model: 0 true OR, 1 stuck-at-0, 2 stuck-at-1, 3 inverted.
  function automatic logic cell_q(input logic [1:0] s, input logic [2:0] v);
    case (s)
      2'd0:    return |v;
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return ~(|v);
    endcase
  endfunction

  assign if_a.i_start = start && (sel == 2'd0);
  assign if_b.i_start = start && (sel == 2'd1);
  assign if_c.i_start = start && (sel == 2'd2);
  assign if_a.i_mode  = mode;
  assign if_b.i_mode  = mode;
  assign if_c.i_mode  = mode;
  assign if_a.i_q = cell_q(qsel, {if_a.o_in3, if_a.o_in2, if_a.o_in1});
  assign if_b.i_q = cell_q(qsel, {if_b.o_in3, if_b.o_in2, if_b.o_in1});
  assign if_c.i_q = cell_q(qsel, {if_c.o_in3, if_c.o_in2, if_c.o_in1});

`ifdef OR3_STIM_GLITCH_CHK_EN
  or3_stim_chk_if #(.CNT_W(16)) if_d ();
  or3_stim_chk #(.SETTLE_CYC(3), .NUM_PASSES(1), .CNT_W(16)) u_d (.i_clk(clk), .i_rstb(rstb), .bus(if_d));
  logic q_lag = 1'b0;
  always @(posedge clk) q_lag <= |{if_d.o_in3, if_d.o_in2, if_d.o_in1};
  assign if_d.i_start = start && (sel == 2'd3);
  assign if_d.i_mode  = mode;
  assign if_d.i_q     = (qsel == 2'd1) ? 1'b0 : q_lag;
`endif

  logic [2:0]  cur_in;
  logic        cur_busy, cur_done, cur_fail;
  logic [15:0] cur_err, cur_tog;

  always_comb begin
    cur_in = {if_a.o_in3, if_a.o_in2, if_a.o_in1};
    cur_busy = if_a.o_busy; cur_done = if_a.o_done; cur_fail = if_a.o_fail;
    cur_err = if_a.o_err_cnt; cur_tog = if_a.o_tog_cnt;
    case (sel)
      2'd1: begin
        cur_in = {if_b.o_in3, if_b.o_in2, if_b.o_in1};
        cur_busy = if_b.o_busy; cur_done = if_b.o_done; cur_fail = if_b.o_fail;
        cur_err = if_b.o_err_cnt; cur_tog = if_b.o_tog_cnt;
      end
      2'd2: begin
        cur_in = {if_c.o_in3, if_c.o_in2, if_c.o_in1};
        cur_busy = if_c.o_busy; cur_done = if_c.o_done; cur_fail = if_c.o_fail;
        cur_err = if_c.o_err_cnt; cur_tog = if_c.o_tog_cnt;
      end
`ifdef OR3_STIM_GLITCH_CHK_EN
      2'd3: begin
        cur_in = {if_d.o_in3, if_d.o_in2, if_d.o_in1};
        cur_busy = if_d.o_busy; cur_done = if_d.o_done; cur_fail = if_d.o_fail;
        cur_err = if_d.o_err_cnt; cur_tog = if_d.o_tog_cnt;
      end
`endif
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_in"},   {29'd0, cur_in}, 32'd0);
    chk({nm, "_busy"}, {31'd0, cur_busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, cur_done}, 32'd0);
    chk({nm, "_fail"}, {31'd0, cur_fail}, 32'd0);
    chk({nm, "_err"},  {16'd0, cur_err}, 32'd0);
    chk({nm, "_tog"},  {16'd0, cur_tog}, 32'd0);
  endtask

  // One run: n counts negedges after the START-accepting posedge (n=0 is DRIVE).
  task automatic do_run(input logic [1:0] s, input logic m, input logic [1:0] q,
                        input int passes, input int per, input int exp_err,
                        input int exp_tog, input int exp_fail, input bit hold,
                        input int pulse_at, input int abort_at);
    int last, busy_n, done_n, done_at, k, ev;
    sel = s; mode = m; qsel = q;
    last = passes * 8 * per;
    busy_n = 0; done_n = 0; done_at = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = hold;
    for (int n = 0; n <= last; n++) begin
      @(negedge clk);
      if (n == abort_at) begin
        #2 rstb = 1'b0;
        #1 chk_idle_zero("async_rst");
        start = 1'b0;
        @(posedge clk); #1 chk("rst_no_done", {31'd0, cur_done}, 32'd0);
        @(negedge clk); rstb = 1'b1;
        return;
      end
      if ((n % per == 2) && (n < last)) begin
        k  = (n / per) % 8;
        ev = m ? (k ^ (k >> 1)) : k;
        chk("vector", {29'd0, cur_in}, ev);
      end
      if (cur_busy) busy_n++;
      if (cur_done) begin
        done_n++;
        if (done_at < 0) done_at = n;
      end
      start = hold || (n == pulse_at);
    end
    chk("done_at",     done_at, last);
    chk("busy_cycles", busy_n, last);
    chk("done_pulses", done_n, 1);
    chk("err_cnt",     {16'd0, cur_err}, exp_err);
    chk("tog_cnt",     {16'd0, cur_tog}, exp_tog);
    chk("fail",        {31'd0, cur_fail}, exp_fail);
    if (!hold) start = 1'b0;
  endtask

  typedef struct {
    logic [1:0] sel;
    logic       mode;
    logic [1:0] qsel;
    int         passes;
    int         err;
    int         tog;
    int         fail;
  } row_t;

  row_t rows[8];

  initial begin
    int busy_n, done_n;
    rstb = 1'b0; start = 1'b0; mode = 1'b0; sel = 2'd0; qsel = 2'd0;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rstb = 1'b1;

    //        sel    mode  qsel   pass err tog fail
    rows[0] = '{2'd0, 1'b0, 2'd0, 1,   0, 11, 0};
    rows[1] = '{2'd0, 1'b1, 2'd0, 1,   0,  7, 0};
    rows[2] = '{2'd0, 1'b0, 2'd1, 1,   7, 11, 1};
    rows[3] = '{2'd0, 1'b1, 2'd2, 1,   1,  7, 1};
    rows[4] = '{2'd0, 1'b0, 2'd3, 1,   8, 11, 1};
    rows[5] = '{2'd0, 1'b0, 2'd0, 1,   0, 11, 0};
    rows[6] = '{2'd1, 1'b1, 2'd0, 4,   0, 31, 0};
    rows[7] = '{2'd2, 1'b0, 2'd1, 2,  14, 25, 1};
    for (int i = 0; i < 8; i++) begin
      do_run(rows[i].sel, rows[i].mode, rows[i].qsel, rows[i].passes, 4,
             rows[i].err, rows[i].tog, rows[i].fail, 1'b0, -1, -1);
    end

    // Reset during pass 1, index 5, then a clean run.
    do_run(2'd2, 1'b0, 2'd1, 2, 4, 0, 0, 0, 1'b0, -1, 54);
    busy_n = 0; done_n = 0;
    repeat (5) begin
      @(negedge clk);
      busy_n += int'(cur_busy); done_n += int'(cur_done);
    end
    chk("post_rst_idle_busy", busy_n, 0);
    chk("post_rst_idle_done", done_n, 0);
    do_run(2'd2, 1'b0, 2'd0, 2, 4, 0, 25, 0, 1'b0, -1, -1);

    // START held high: one run, FINISH ignores START, next IDLE accepts it.
    do_run(2'd0, 1'b0, 2'd0, 1, 4, 0, 11, 0, 1'b1, -1, -1);
    @(negedge clk); chk("held_gap_busy", {31'd0, cur_busy}, 32'd0);
    @(negedge clk); chk("held_restart_busy", {31'd0, cur_busy}, 32'd1);
    start = 1'b0;
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      done_n += int'(cur_done);
    end
    chk("held_second_done", done_n, 1);

    // START pulsed while BUSY is ignored.
    do_run(2'd0, 1'b1, 2'd0, 1, 4, 0, 7, 0, 1'b0, 10, -1);
    busy_n = 0;
    repeat (6) begin
      @(negedge clk);
      busy_n += int'(cur_busy);
    end
    chk("pulse_no_restart", busy_n, 0);

`ifdef OR3_STIM_GLITCH_CHK_EN
    do_run(2'd3, 1'b0, 2'd1, 1, 5, 7, 11, 1, 1'b0, -1, -1);
    chk("glitch_stuck0", {16'd0, if_d.o_glitch_cnt}, 32'd14);
    do_run(2'd3, 1'b0, 2'd0, 1, 5, 0, 11, 0, 1'b0, -1, -1);
    chk("glitch_lag1", {16'd0, if_d.o_glitch_cnt}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
